// File: rtl/bp_me_wormhole_cmd_serializer_if.sv
// -----------------------------------------------------------------------------
// bp_me_wormhole_cmd_serializer_if
//
// Bundles the command-side valid/ready handshake and the flit-side valid/ready
// link of the wormhole command serializer.
//
//   payload_i  command payload               (producer -> serializer)
//   dst_id_i   destination LCE id            (producer -> serializer)
//   short_i    command carries no block data (producer -> serializer)
//   v_i        command valid                 (producer -> serializer)
//   ready_o    command accepted on v_i & ready_o   (serializer -> producer)
//   flit_o     current flit                  (serializer -> router)
//   v_o        flit valid                    (serializer -> router)
//   ready_i    router accepts on v_o & ready_i     (router -> serializer)
//
// Modports: slave = serializer side, master = producer/router side.
// -----------------------------------------------------------------------------
interface bp_me_wormhole_cmd_serializer_if #(
  parameter int payload_width_p = 121,
  parameter int lce_id_width_p  = 4,
  parameter int flit_width_p    = 32
);
  logic [payload_width_p-1:0] payload_i;
  logic [lce_id_width_p-1:0]  dst_id_i;
  logic                       short_i;
  logic                       v_i;
  logic                       ready_o;
  logic [flit_width_p-1:0]    flit_o;
  logic                       v_o;
  logic                       ready_i;

  modport slave (
    input  payload_i, dst_id_i, short_i, v_i, ready_i,
    output ready_o, flit_o, v_o
  );

  modport master (
    output payload_i, dst_id_i, short_i, v_i, ready_i,
    input  ready_o, flit_o, v_o
  );
endinterface

// File: rtl/bp_me_wormhole_cmd_serializer.sv
// -----------------------------------------------------------------------------
// bp_me_wormhole_cmd_serializer
//
// Accepts one CCE->LCE command per valid/ready handshake, prepends wormhole
// routing (x/y from the destination LCE id) and a length field, and streams
// the packet LSB-first as flit_width_p-bit flits. Packet layout, LSB first:
// {payload', len, y_cord, x_cord}, zero-padded to max_num_flit_p flits.
//
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset; drops any packet in flight
//   cmd        bp_me_wormhole_cmd_serializer_if.slave (command in, flits out)
//
// Build option: define BP_ME_WORMHOLE_SHORT_PKT_EN to enable short packets,
// which drop the top (block_size_in_bits_p - data_width_p) payload bits when
// short_i is set. Without it short_i is ignored and every packet is full.
// -----------------------------------------------------------------------------
module bp_me_wormhole_cmd_serializer #(
  parameter int payload_width_p      = 121,
  parameter int block_size_in_bits_p = 64,
  parameter int data_width_p         = 64,
  parameter int lce_id_width_p       = 4,
  parameter int x_cord_width_p       = 2,
  parameter int y_cord_width_p       = 2,
  parameter int max_num_flit_p       = 8,
  parameter int flit_width_p         = 32
) (
  input logic                           clk_i,
  input logic                           reset_n_i,
  bp_me_wormhole_cmd_serializer_if.slave cmd
);

  localparam int len_width_lp = $clog2(max_num_flit_p);
  localparam int full_pkt_w   = x_cord_width_p + y_cord_width_p + len_width_lp + payload_width_p;
  localparam int full_flits   = (full_pkt_w + flit_width_p - 1) / flit_width_p;
  localparam int buf_w        = max_num_flit_p * flit_width_p;

  localparam logic [len_width_lp-1:0] full_len_lp = len_width_lp'(full_flits - 1);

`ifdef BP_ME_WORMHOLE_SHORT_PKT_EN
  localparam int trim_w      = block_size_in_bits_p - data_width_p;
  localparam int short_pkt_w = full_pkt_w - trim_w;
  localparam int short_flits = (short_pkt_w + flit_width_p - 1) / flit_width_p;

  localparam logic [len_width_lp-1:0] short_len_lp = len_width_lp'(short_flits - 1);
`endif

  if (full_flits > max_num_flit_p) begin : g_too_many_flits
    $error("full packet needs more flits than max_num_flit_p");
  end
  if (data_width_p > block_size_in_bits_p) begin : g_bad_data_width
    $error("data_width_p must not exceed block_size_in_bits_p");
  end

  typedef enum logic {
    e_idle,
    e_send
  } state_e;

  typedef logic [max_num_flit_p-1:0][flit_width_p-1:0] pkt_t;

  state_e                    state_r;
  logic [len_width_lp-1:0]   cnt_r;
  logic [len_width_lp-1:0]   len_r;
  pkt_t                      pkt_r;

  logic [x_cord_width_p-1:0] x_cord;
  logic [y_cord_width_p-1:0] y_cord;
  logic [len_width_lp-1:0]   len_next;
  pkt_t                      pkt_next;
  logic                      last_flit;
  logic                      accept;

  // Packet assembly from the current command inputs; only captured on accept.
  always_comb begin
    // NOTE: every output of this block is given a value before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    x_cord   = cmd.dst_id_i[x_cord_width_p-1:0];
    y_cord   = y_cord_width_p'(cmd.dst_id_i >> x_cord_width_p);
    len_next = full_len_lp;
    pkt_next = pkt_t'(buf_w'({cmd.payload_i, full_len_lp, y_cord, x_cord}));
`ifdef BP_ME_WORMHOLE_SHORT_PKT_EN
    if (cmd.short_i) begin
      // Block occupies the payload MSBs, so dropping its top trim_w bits keeps
      // the low data_width_p bits of the block and everything beneath it.
      len_next = short_len_lp;
      pkt_next = pkt_t'(buf_w'({cmd.payload_i[payload_width_p-trim_w-1:0],
                                short_len_lp, y_cord, x_cord}));
    end
`endif
  end

`ifndef BP_ME_WORMHOLE_SHORT_PKT_EN
  logic unused_short;
  assign unused_short = cmd.short_i;
`endif

  assign last_flit   = (cnt_r == len_r);
  // Combinational from ready_i so a new command can be taken in the same cycle
  // as the last flit leaves, giving bubble-free back-to-back packets.
  assign cmd.ready_o = (state_r == e_idle) |
                       ((state_r == e_send) & cmd.ready_i & last_flit);
  assign accept      = cmd.v_i & cmd.ready_o;

  assign cmd.v_o     = (state_r == e_send);
  assign cmd.flit_o  = pkt_r[cnt_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      cnt_r   <= '0;
      len_r   <= '0;
      // NOTE: the packet register is a plain register (not a RAM) and is
      // cleared so flit_o reads as zero out of reset.
      pkt_r   <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register update in this
      // block based on pre-edge values, independent of statement order.
      state_r <= e_send;
      cnt_r   <= '0;
      len_r   <= len_next;
      pkt_r   <= pkt_next;
    end else if ((state_r == e_send) && cmd.ready_i) begin
      if (last_flit) begin
        state_r <= e_idle;
        cnt_r   <= '0;
      end else begin
        cnt_r   <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_me_wormhole_cmd_serializer.sv
module tb_bp_me_wormhole_cmd_serializer;

  localparam int payload_w = 121;

  logic clk;
  logic reset_n;

  bp_me_wormhole_cmd_serializer_if #(
    .payload_width_p(payload_w),
    .lce_id_width_p (4),
    .flit_width_p   (32)
  ) cmd_if ();

  bp_me_wormhole_cmd_serializer #(
    .payload_width_p     (payload_w),
    .block_size_in_bits_p(64),
    .data_width_p        (32),
    .lce_id_width_p      (4),
    .x_cord_width_p      (2),
    .y_cord_width_p      (2),
    .max_num_flit_p      (8),
    .flit_width_p        (32)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .cmd      (cmd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flit;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   hs_cnt   = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  int   pidx     = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference packet model: builds the packet from the field definitions and
  // queues its flits in transmission order.
  function automatic void push_pkt(input logic [payload_w-1:0] p, input logic [3:0] d,
                                   input bit s);
    logic [127:0] pkt;
    logic [1:0]   x;
    logic [1:0]   y;
    int           n;
    exp_t         e;
    x   = d[1:0];
    y   = d[3:2];
    pkt = {p, 3'd3, y, x};
    n   = 4;
`ifdef BP_ME_WORMHOLE_SHORT_PKT_EN
    if (s) begin
      pkt = {32'd0, p[88:0], 3'd2, y, x};
      n   = 3;
    end
`else
    if (s) n = 4;
`endif
    for (int i = 0; i < n; i++) begin
      e.flit = pkt[i*32 +: 32];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Link-side ready generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       cmd_if.ready_i = 1'b1;
      1: begin
        cmd_if.ready_i = (pidx == 0) || (pidx == 3);
        pidx = (pidx + 1) % 4;
      end
      default: cmd_if.ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard monitor: sampled on the falling edge, where the values that
  // the next rising edge will act on are stable.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd_if.v_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit_v_o", cmd_if.v_o, 1'b0);
        end else begin
          check("flit", cmd_if.flit_o, exp_q[0].flit);
          check("ready_o_send", cmd_if.ready_o, cmd_if.ready_i & exp_q[0].last);
          if (cmd_if.ready_i) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        check("ready_o_idle", cmd_if.ready_o, 1'b1);
      end
    end
  end

  // Called just after a rising edge (or on a falling edge). Returns once the
  // command has been accepted, positioned 2 time units after the accepting edge.
  task automatic send_cmd(input logic [payload_w-1:0] p, input logic [3:0] d, input bit s,
                          input bit keep_v, output int waited);
    int n;
    n = 0;
    cmd_if.payload_i = p;
    cmd_if.dst_id_i  = d;
    cmd_if.short_i   = s;
    cmd_if.v_i       = 1'b1;
    push_pkt(p, d, s);
    while (!cmd_if.ready_o && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) check("accept_timeout", cmd_if.ready_o, 1'b1);
    waited = n;
    @(posedge clk);
    #2;
    check("latency_v_o", cmd_if.v_o, 1'b1);
    if (!keep_v) cmd_if.v_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_if.v_o) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain", {cmd_if.v_o, 32'(exp_q.size())}, '0);
  endtask

  function automatic logic [payload_w-1:0] rand_payload();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[payload_w-1:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int hs0;
    int n;
    logic [payload_w-1:0] p1;

    reset_n          = 1'b0;
    cmd_if.v_i       = 1'b1;
    cmd_if.payload_i = rand_payload();
    cmd_if.dst_id_i  = 4'd3;
    cmd_if.short_i   = 1'b0;
    cmd_if.ready_i   = 1'b1;

    // Reset held with v_i high: nothing may be accepted or sent.
    repeat (3) @(posedge clk);
    #2;
    check("reset_v_o", cmd_if.v_o, 1'b0);
    check("reset_ready_o", cmd_if.ready_o, 1'b1);
    check("reset_flit_o", cmd_if.flit_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full packet to dst 6: accepted on the first edge after release.
    p1 = rand_payload();
    send_cmd(p1, 4'd6, 1'b0, 1'b0, waited);
    check("first_accept_next_edge", waited, 0);
    check("flit0_x", cmd_if.flit_o[1:0], 2'd2);
    check("flit0_y", cmd_if.flit_o[3:2], 2'd1);
    check("flit0_len", cmd_if.flit_o[6:4], 3'd3);
    wait_drain();

    // Short command to dst 1.
    send_cmd(rand_payload(), 4'd1, 1'b1, 1'b0, waited);
`ifdef BP_ME_WORMHOLE_SHORT_PKT_EN
    check("short_len", cmd_if.flit_o[6:4], 3'd2);
`else
    check("short_len", cmd_if.flit_o[6:4], 3'd3);
`endif
    wait_drain();

    // Backpressure with a 1,0,0,1 ready pattern.
    rdy_mode = 1;
    send_cmd(rand_payload(), 4'd9, 1'b0, 1'b0, waited);
    send_cmd(rand_payload(), 4'd14, 1'b1, 1'b0, waited);
    wait_drain();

    // Back-to-back full packets with ready held high: 8 flits in 8 cycles.
    rdy_mode = 0;
    @(posedge clk);
    #2;
    send_cmd(rand_payload(), 4'd2, 1'b0, 1'b1, waited);
    hs0 = hs_cnt;
    send_cmd(rand_payload(), 4'd13, 1'b0, 1'b0, waited);
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    check("b2b_throughput", hs_cnt - hs0, 8);
    check("b2b_idle_after", cmd_if.v_o, 1'b0);
    wait_drain();

    // Reset after flit 1 of a 4-flit packet.
    send_cmd(rand_payload(), 4'd6, 1'b0, 1'b0, waited);
    hs0 = hs_cnt;
    n   = 0;
    while (hs_cnt < hs0 + 2 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("midreset_flits_before", hs_cnt - hs0, 2);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_v_o", cmd_if.v_o, 1'b0);
    check("midreset_ready_o", cmd_if.ready_o, 1'b1);
    check("midreset_flit_o", cmd_if.flit_o, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_cmd(rand_payload(), 4'd5, 1'b0, 1'b0, waited);
    check("postreset_accept", waited, 0);
    wait_drain();

    // Random commands with random link backpressure, some back-to-back.
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) begin
      send_cmd(rand_payload(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               (i != 7) && ($urandom_range(0, 1) == 1), waited);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_me_wormhole_cmd_serializer.md
# bp_me_wormhole_cmd_serializer

Sequential successor to the combinational command packet encoder. Accepts one CCE→LCE command per valid/ready handshake, derives wormhole routing (x/y coordinates from the destination LCE id) and a length field, then emits the packet LSB-first as a stream of fixed-width flits into the wormhole router. Commands without a data block can be sent as shortened packets that carry only the low `data_width_p` bits of the block.

## Interface
- `payload_width_p`, "inv": width of the command payload; the data block occupies the top `block_size_in_bits_p` bits.
- `block_size_in_bits_p`, "inv": width of the data block field in the payload.
- `data_width_p`, 64: data bits retained in a short packet; must be ≤ `block_size_in_bits_p`.
- `lce_id_width_p`, "inv": width of `dst_id_i`.
- `x_cord_width_p`, "inv": routing x field width. `lce_x_dim_p` = 2^`x_cord_width_p`.
- `y_cord_width_p`, "inv": routing y field width.
- `max_num_flit_p`, "inv": maximum flits per packet; len field width `len_width_lp` = clog2(`max_num_flit_p`).
- `flit_width_p`, "inv": link flit width.
- Derived: `full_pkt_w` = x+y+len+`payload_width_p`; `short_pkt_w` = `full_pkt_w` − (`block_size_in_bits_p` − `data_width_p`); `full_flits`/`short_flits` = ceil(width/`flit_width_p`). Elaboration error if `full_flits` > `max_num_flit_p`.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `payload_i` in `payload_width_p`: command.
- `dst_id_i` in `lce_id_width_p`: destination LCE.
- `short_i` in 1: command carries no block data.
- `v_i` in 1: command valid.
- `ready_o` out 1: command accepted when `v_i & ready_o`.
- `flit_o` out `flit_width_p`: current flit.
- `v_o` out 1: flit valid.
- `ready_i` in 1: link accepts flit when `v_o & ready_i`.

## Operation
- Packet = {payload', len, y_cord, x_cord}, with x_cord at the LSBs. x_cord = `dst_id_i[x_cord_width_p-1:0]`; y_cord = `dst_id_i` >> `x_cord_width_p`, truncated to `y_cord_width_p`.
- Full packet: payload' = `payload_i`, len = `full_flits`−1.
- Short packet: payload' = `payload_i` with its top (`block_size_in_bits_p`−`data_width_p`) bits removed; len = `short_flits`−1.
- The packet is zero-extended to `max_num_flit_p`·`flit_width_p` and held in a register. Flit k = bits [k·`flit_width_p` +: `flit_width_p`]. Padding bits in the last flit are 0.
- FSM states:
  - IDLE: `ready_o`=1, `v_o`=0. On `v_i`: latch the packet and len, clear the counter, go to SEND.
  - SEND: `v_o`=1, `flit_o` = flit[cnt]. On `ready_i`: cnt++. When cnt == len, the flit is the last one.
  - After the last flit handshake: if `v_i` is high in the same cycle, latch the new packet, set cnt=0 and stay in SEND (back-to-back, no bubble). Otherwise go to IDLE.
- `ready_o` = IDLE | (SEND & `ready_i` & cnt==len). This is combinational from `ready_i`.
- Inputs are sampled only at the accepting handshake. Changes at other times are ignored.
- `flit_o` is stable while `v_o` is high and `ready_i` is low.

## Timing
- Reset (asynchronous, `reset_n_i`=0): state=IDLE, cnt=0, packet register=0. `v_o`=0, `ready_o`=1, `flit_o`=0.
- Reset asserted mid-packet: the packet is dropped immediately, with no partial completion. The first cycle after deassertion is in IDLE.
- Latency: command accepted in cycle t → flit 0 presented with `v_o` in cycle t+1.
- A packet of N flits occupies at least N cycles in SEND. Sustained throughput is 1 flit/cycle with `ready_i` held high, including across packet boundaries.
- cnt is `len_width_lp` bits and never wraps; it stops at len.

## Configuration
- `BP_ME_WORMHOLE_SHORT_PKT_EN` defined: short packets as described above.
- Macro undefined: `short_i` is ignored. Every command is sent as a full packet with len = `full_flits`−1, and the short-path logic is not compiled.

## Test plan
Parameters: payload 121, block 64, data 32, x=y=2, max_num_flit 8 (len 3), flit 32. Full packet = 128 bits = 4 flits; short packet = 96 bits = 3 flits.
- Reset: hold `reset_n_i`=0 with `v_i`=1 → `v_o`=0, `ready_o`=1. After release, the first accept occurs next edge.
- Full command with dst_id=6, `ready_i`=1 → `ready_o` low for 3 cycles. Then:
  - 4 flits on consecutive cycles.
  - flit0[1:0]=2 (x), [3:2]=1 (y), [6:4]=3 (len).
  - Concatenated flits equal {payload, 3'd3, 2'd1, 2'd2}.
- Short command (macro on), dst_id=1 → 3 flits, len=2. Flit 2 carries payload bits up to block bit 31, zero-padded.
  - With the macro off, the same stimulus gives 4 flits and len=3.
- Backpressure: toggle `ready_i` 1,0,0,1,… → `flit_o` holds while stalled and no flit is skipped or duplicated.
- Back-to-back: `v_i` held high with two commands → the second packet's flit 0 follows the first packet's last flit in the next cycle, and `ready_o` pulses only on last-flit handshakes.
- Reset asserted after flit 1 of a 4-flit packet → `v_o` drops asynchronously. After release, the next command starts again from flit 0.
